// File: rtl/result_display_scan.sv
// Display stage: latches each executed instruction's opcode, destination, ALU result and flags,
// then scans them onto a 4-digit active-low 7-segment display, blinking the result digit on a flag.
module result_display_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_TICKS = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        result_valid,
  input  logic [15:0] instruction,
  input  logic [3:0]  alu_result,
  input  logic        overflow,
  input  logic        underflow,
  output logic [6:0]  ssd_seg,
  output logic [3:0]  ssd_anode
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [RW-1:0] REF_MAX = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_TICKS - 1);

  logic [RW-1:0] ref_cnt_r;
  logic [BW-1:0] blk_cnt_r;
  logic [1:0]    idx_r;
  logic          phase_on_r;
  logic          has_result_r;
  logic [3:0]    opcode_r;
  logic [3:0]    dest_r;
  logic [3:0]    result_r;
  logic          ovf_r;
  logic          unf_r;
  logic [6:0]    ssd_seg_r;
  logic [3:0]    ssd_anode_r;

  logic          tick_s;
  logic          blk_wrap_s;
  logic [1:0]    idx_next_s;
  logic [6:0]    seg_next_s;
  logic [3:0]    anode_next_s;

  function automatic logic [6:0] hex_glyph(input logic [3:0] value);
    logic [6:0] glyph;
    case (value)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      4'hF: glyph = 7'h0E;
      default: glyph = 7'h7F;
    endcase
    return glyph;
  endfunction

  function automatic logic [6:0] flag_glyph(input logic ovf, input logic unf);
    logic [6:0] glyph;
    case ({ovf, unf})
      2'b00:   glyph = 7'h7F;
      2'b10:   glyph = 7'h7E;
      2'b01:   glyph = 7'h77;
      2'b11:   glyph = 7'h76;
      default: glyph = 7'h7F;
    endcase
    return glyph;
  endfunction

  // Next digit selection and glyph, built from pre-edge latched values and phase
  always_comb begin
    tick_s       = (ref_cnt_r == REF_MAX);
    blk_wrap_s   = tick_s && (blk_cnt_r == BLK_MAX);
    idx_next_s   = idx_r + 2'd1;
    anode_next_s = 4'b1111;
    seg_next_s   = 7'h7F;
    case (idx_next_s)
      2'd0:    anode_next_s = 4'b1110;
      2'd1:    anode_next_s = 4'b1101;
      2'd2:    anode_next_s = 4'b1011;
      2'd3:    anode_next_s = 4'b0111;
      default: anode_next_s = 4'b1111;
    endcase
    if (!has_result_r) begin
      seg_next_s = 7'h3F;
    end else begin
      case (idx_next_s)
        2'd0: begin
          // Blanked in the off phase, but only while a flag is latched
          if ((ovf_r || unf_r) && !phase_on_r) begin
            seg_next_s = 7'h7F;
          end else begin
            seg_next_s = hex_glyph(result_r);
          end
        end
        2'd1:    seg_next_s = flag_glyph(ovf_r, unf_r);
        2'd2:    seg_next_s = hex_glyph(dest_r);
        2'd3:    seg_next_s = hex_glyph(opcode_r);
        default: seg_next_s = 7'h7F;
      endcase
    end
  end

  // Refresh divider and scan index
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt_r <= '0;
      idx_r     <= 2'd3;
    end else if (tick_s) begin
      ref_cnt_r <= '0;
      idx_r     <= idx_next_s;
    end else begin
      ref_cnt_r <= ref_cnt_r + RW'(1);
    end
  end

  // Result capture on the strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      has_result_r <= 1'b0;
      opcode_r     <= 4'h0;
      dest_r       <= 4'h0;
      result_r     <= 4'h0;
      ovf_r        <= 1'b0;
      unf_r        <= 1'b0;
    end else if (result_valid) begin
      has_result_r <= 1'b1;
      opcode_r     <= instruction[15:12];
      dest_r       <= instruction[3:0];
      result_r     <= alu_result;
      ovf_r        <= overflow;
      unf_r        <= underflow;
    end
  end

  // Blink timing; a new result restarts the on phase even on a wrap edge
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_cnt_r  <= '0;
      phase_on_r <= 1'b1;
    end else if (result_valid) begin
      blk_cnt_r  <= '0;
      phase_on_r <= 1'b1;
    end else if (blk_wrap_s) begin
      blk_cnt_r  <= '0;
      phase_on_r <= !phase_on_r;
    end else if (tick_s) begin
      blk_cnt_r  <= blk_cnt_r + BW'(1);
    end
  end

  // Registered pin drivers
  always_ff @(posedge clk) begin
    if (rst) begin
      ssd_seg_r   <= 7'h7F;
      ssd_anode_r <= 4'b1111;
    end else if (tick_s) begin
      ssd_seg_r   <= seg_next_s;
      ssd_anode_r <= anode_next_s;
    end
  end

  assign ssd_seg   = ssd_seg_r;
  assign ssd_anode = ssd_anode_r;

endmodule

// File: tb/tb_result_display_scan.sv
// Scoreboard bench for result_display_scan: a cycle model pushes expected pin values per edge,
// which are popped and compared after each edge, plus fixed-value spot checks.
module tb_result_display_scan;

  localparam int DIV = 4;
  localparam int BT  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        result_valid = 1'b0;
  logic [15:0] instruction = 16'h0000;
  logic [3:0]  alu_result = 4'h0;
  logic        overflow = 1'b0;
  logic        underflow = 1'b0;
  logic [6:0]  ssd_seg;
  logic [3:0]  ssd_anode;

  result_display_scan #(.REFRESH_DIV(DIV), .BLINK_TICKS(BT)) dut (
    .clk(clk), .rst(rst), .result_valid(result_valid), .instruction(instruction),
    .alu_result(alu_result), .overflow(overflow), .underflow(underflow),
    .ssd_seg(ssd_seg), .ssd_anode(ssd_anode)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [10:0] sb_q[$];

  logic [6:0] seg7 [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // model state
  int m_cnt, m_idx, m_bcnt;
  bit m_ph, m_has, m_ovf, m_unf;
  logic [3:0] m_op, m_dst, m_res, m_an;
  logic [6:0] m_sg;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit tick;
    int ni;
    logic [3:0] one;
    logic [3:0] an;
    logic [6:0] sg;
    if (rst) begin
      m_cnt = 0; m_idx = 3; m_bcnt = 0; m_ph = 1'b1; m_has = 1'b0;
      m_ovf = 1'b0; m_unf = 1'b0; m_op = 4'h0; m_dst = 4'h0; m_res = 4'h0;
      m_an = 4'hF; m_sg = 7'h7F;
    end else begin
      tick = (m_cnt == DIV - 1);
      ni = (m_idx + 1) % 4;
      one = 4'b0001;
      an = ~(one << ni);
      if (!m_has) sg = 7'h3F;
      else if (ni == 0) sg = ((m_ovf || m_unf) && !m_ph) ? 7'h7F : seg7[m_res];
      else if (ni == 1) sg = m_ovf ? (m_unf ? 7'h76 : 7'h7E) : (m_unf ? 7'h77 : 7'h7F);
      else if (ni == 2) sg = seg7[m_dst];
      else sg = seg7[m_op];
      m_cnt = tick ? 0 : m_cnt + 1;
      if (result_valid) begin
        m_has = 1'b1; m_op = instruction[15:12]; m_dst = instruction[3:0];
        m_res = alu_result; m_ovf = overflow; m_unf = underflow;
        m_bcnt = 0; m_ph = 1'b1;
      end else if (tick) begin
        if (m_bcnt == BT - 1) begin
          m_bcnt = 0; m_ph = !m_ph;
        end else begin
          m_bcnt = m_bcnt + 1;
        end
      end
      if (tick) begin
        m_idx = ni; m_an = an; m_sg = sg;
      end
    end
    sb_q.push_back({m_an, m_sg});
  endtask

  task automatic cycle(input logic r, input logic rv, input logic [15:0] ins,
                       input logic [3:0] res, input logic ov, input logic un);
    logic [10:0] exp;
    rst = r; result_valid = rv; instruction = ins; alu_result = res;
    overflow = ov; underflow = un;
    model_edge();
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 16'd0, 16'd1);
    end else begin
      exp = sb_q.pop_front();
      chk("pins", {5'd0, ssd_anode, ssd_seg}, {5'd0, exp});
    end
    // garbage on inputs outside strobe cycles must not matter
    instruction = 16'($urandom); alu_result = 4'($urandom);
    overflow = 1'($urandom); underflow = 1'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'($urandom), 4'($urandom), 1'b0, 1'b0);
  endtask

  task automatic strobe(input logic [15:0] ins, input logic [3:0] res, input logic ov, input logic un);
    cycle(1'b0, 1'b1, ins, res, ov, un);
  endtask

  // leave the current slot for digit a (if in it), then run until it is driven again
  task automatic next_slot(input logic [3:0] a, input string tag);
    int n = 0;
    while (ssd_anode === a && n < 64) begin idle(1); n++; end
    while (ssd_anode !== a && n < 64) begin idle(1); n++; end
    chk({tag, "_reached"}, {12'd0, ssd_anode}, {12'd0, a});
  endtask

  initial begin
    // reset, no result
    cycle(1'b1, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
    chk("rst_anode", {12'd0, ssd_anode}, 16'h000F);
    chk("rst_seg", {9'd0, ssd_seg}, 16'h007F);
    idle(3);
    chk("pre_first_anode", {12'd0, ssd_anode}, 16'h000F);
    idle(1);
    chk("first_anode", {12'd0, ssd_anode}, 16'h000E);
    chk("first_seg_dash", {9'd0, ssd_seg}, 16'h003F);
    idle(16);

    // normal result
    strobe(16'hA125, 4'h5, 1'b0, 1'b0);
    next_slot(4'b1110, "norm_d0"); chk("norm_d0", {9'd0, ssd_seg}, 16'h0012);
    next_slot(4'b1101, "norm_d1"); chk("norm_d1", {9'd0, ssd_seg}, 16'h007F);
    next_slot(4'b1011, "norm_d2"); chk("norm_d2", {9'd0, ssd_seg}, 16'h0012);
    next_slot(4'b0111, "norm_d3"); chk("norm_d3", {9'd0, ssd_seg}, 16'h0008);
    idle(40);

    // overflow blink: latched at the start of a d0 slot -> next d0 falls in the off phase
    next_slot(4'b1110, "ovf_align");
    strobe(16'h3000, 4'h0, 1'b1, 1'b0);
    next_slot(4'b1101, "ovf_d1"); chk("ovf_d1", {9'd0, ssd_seg}, 16'h007E);
    next_slot(4'b1110, "ovf_d0_off"); chk("ovf_d0_off", {9'd0, ssd_seg}, 16'h007F);
    idle(24);
    // latched during d3 -> next d0 is in the on phase
    next_slot(4'b0111, "ovf_align2");
    strobe(16'h3000, 4'h0, 1'b1, 1'b0);
    next_slot(4'b1110, "ovf_d0_on"); chk("ovf_d0_on", {9'd0, ssd_seg}, 16'h0040);
    idle(40);

    // both flags, then clear
    strobe(16'h6007, 4'h9, 1'b1, 1'b1);
    next_slot(4'b1101, "both_d1"); chk("both_d1", {9'd0, ssd_seg}, 16'h0076);
    idle(20);
    strobe(16'hA125, 4'hF, 1'b0, 1'b0);
    next_slot(4'b1110, "clr_d0"); chk("clr_d0", {9'd0, ssd_seg}, 16'h000E);
    next_slot(4'b1101, "clr_d1"); chk("clr_d1", {9'd0, ssd_seg}, 16'h007F);
    idle(40);

    // strobe on a tick edge
    for (int i = 0; i < 8 && m_cnt != DIV - 1; i++) idle(1);
    strobe(16'h7C09, 4'h3, 1'b0, 1'b1);
    idle(24);

    // strobe on a blink-wrap edge
    strobe(16'h2004, 4'h1, 1'b1, 1'b0);
    for (int i = 0; i < 64 && !(m_cnt == DIV - 1 && m_bcnt == BT - 1); i++) idle(1);
    strobe(16'hD00B, 4'h8, 1'b1, 1'b0);
    idle(48);

    // reset mid-scan
    idle(6);
    cycle(1'b1, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
    chk("mid_rst_anode", {12'd0, ssd_anode}, 16'h000F);
    chk("mid_rst_seg", {9'd0, ssd_seg}, 16'h007F);
    idle(3);
    chk("mid_rst_hold", {12'd0, ssd_anode}, 16'h000F);
    idle(1);
    chk("mid_rst_d0", {12'd0, ssd_anode}, 16'h000E);
    chk("mid_rst_dash", {9'd0, ssd_seg}, 16'h003F);
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
